cc_matrix_max7219_tx: RTL and testbench

- Serial transmitter that consumes the eight 8-bit row buses (fila7..fila0) produced by the pattern generators.
- Drives one 8x8 LED matrix through a MAX7219 over its 3-wire serial link (DIN, CLK, LOAD).
- After reset it sends the MAX7219 configuration words, then refreshes all eight digit registers continuously from a per-frame snapshot of the row buses.
- Sits between the game/transition pattern muxes and the board pins.

---
 rtl/cc_matrix_max7219_tx_pkg.sv | 43 ++++
 rtl/cc_max7219_word_tx.sv | 100 ++++++++++
 rtl/cc_matrix_max7219_tx.sv | 111 +++++++++++
 tb/tb_cc_matrix_max7219_tx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_matrix_max7219_tx_pkg.sv
// Shared constants for the MAX7219 matrix transmitter: register map,
// sequencing counts, state encodings and the init-word table.
package cc_matrix_max7219_tx_pkg;

    localparam logic [7:0] REG_NOOP      = 8'h00;
    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_DISPTEST  = 8'h0F;

    localparam int INIT_WORDS  = 5;
    localparam int DIGIT_WORDS = 8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_SNAP,
        ST_REFRESH,
        ST_IDLE
    } matrix_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_HIGH,
        PH_LOW,
        PH_LATCH
    } tx_phase_t;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {REG_DISPTEST, 8'h00};
            3'd1:    w = {REG_SCANLIMIT, 8'h07};
            3'd2:    w = {REG_DECODE, 8'h00};
            3'd3:    w = {REG_INTENSITY, 4'h0, intensity};
            default: w = {REG_SHUTDOWN, 8'h01};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cc_max7219_word_tx.sv
// Shifts one 16-bit MAX7219 word out MSB first over DIN/CLK/LOAD,
// framed by a setup half-period and a double-length latch period.
//
// state    | meaning
// PH_IDLE  | load high, waiting for start
// PH_SETUP | load low, din = bit15, sclk low
// PH_HIGH  | sclk high, din held
// PH_LOW   | sclk low, din advanced to next bit (0 after bit0)
// PH_LATCH | load high for two half-periods; done on the last cycle
module cc_max7219_word_tx
    import cc_matrix_max7219_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        start,
    input  logic [15:0] word,
    output logic        busy,
    output logic        done,
    output logic        din,
    output logic        sclk,
    output logic        load
);

    localparam logic [8:0] HALF_LD  = 9'(CLK_DIV - 1);
    localparam logic [8:0] LATCH_LD = 9'(2 * CLK_DIV - 1);

    tx_phase_t   phase, phase_nxt;
    logic [8:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg;
    logic        tc;

    assign tc = (div_cnt == 9'd0);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) phase <= PH_IDLE;
        else        phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = phase;
        case (phase)
            PH_IDLE:  if (start) phase_nxt = PH_SETUP;
            PH_SETUP: if (tc) phase_nxt = PH_HIGH;
            PH_HIGH:  if (tc) phase_nxt = PH_LOW;
            PH_LOW:   if (tc) phase_nxt = (bit_cnt == 4'd15) ? PH_LATCH : PH_HIGH;
            PH_LATCH: if (tc) phase_nxt = PH_IDLE;
            default:  phase_nxt = PH_IDLE;
        endcase
    end

    // Shift on the HIGH->LOW boundary so din never moves while sclk is high.
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            div_cnt <= 9'd0;
            bit_cnt <= 4'd0;
            shreg   <= 16'd0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        div_cnt <= HALF_LD;
                        bit_cnt <= 4'd0;
                        shreg   <= word;
                    end
                end
                PH_SETUP: div_cnt <= tc ? HALF_LD : div_cnt - 9'd1;
                PH_HIGH: begin
                    if (tc) begin
                        div_cnt <= HALF_LD;
                        shreg   <= {shreg[14:0], 1'b0};
                    end else begin
                        div_cnt <= div_cnt - 9'd1;
                    end
                end
                PH_LOW: begin
                    if (!tc) begin
                        div_cnt <= div_cnt - 9'd1;
                    end else if (bit_cnt == 4'd15) begin
                        div_cnt <= LATCH_LD;
                    end else begin
                        div_cnt <= HALF_LD;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                PH_LATCH: if (!tc) div_cnt <= div_cnt - 9'd1;
                default: ;
            endcase
        end
    end

    assign busy = (phase != PH_IDLE);
    assign done = (phase == PH_LATCH) && tc;
    assign sclk = (phase == PH_HIGH);
    assign load = (phase == PH_IDLE) || (phase == PH_LATCH);
    assign din  = shreg[15] && ((phase == PH_SETUP) || (phase == PH_HIGH) || (phase == PH_LOW));

endmodule

// File: rtl/cc_matrix_max7219_tx.sv
// MAX7219 8x8 matrix driver: sends the init words once after reset, then
// refreshes the eight digit registers from a per-frame row snapshot.
//
// state      | meaning
// ST_INIT    | sending the five configuration words
// ST_SNAP    | one cycle: capture all row buses, reset word index
// ST_REFRESH | sending digit words 1..8 from the snapshot
// ST_IDLE    | parked at reset levels until enable returns
module cc_matrix_max7219_tx
    import cc_matrix_max7219_tx_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic       matrix_CLOCK_50,
    input  logic       matrix_RESET_InLow,
    input  logic       matrix_enable_in,
    input  logic [7:0] matrix_fila7_bus_in,
    input  logic [7:0] matrix_fila6_bus_in,
    input  logic [7:0] matrix_fila5_bus_in,
    input  logic [7:0] matrix_fila4_bus_in,
    input  logic [7:0] matrix_fila3_bus_in,
    input  logic [7:0] matrix_fila2_bus_in,
    input  logic [7:0] matrix_fila1_bus_in,
    input  logic [7:0] matrix_fila0_bus_in,
    output logic       matrix_din_out,
    output logic       matrix_sclk_out,
    output logic       matrix_load_out,
    output logic       matrix_busy_out,
    output logic       matrix_frame_done_out
);

    localparam logic [2:0] LAST_INIT  = 3'(INIT_WORDS - 1);
    localparam logic [2:0] LAST_DIGIT = 3'(DIGIT_WORDS - 1);

    matrix_state_t state, state_nxt;
    logic [2:0]    word_idx;
    logic [63:0]   snap;
    logic          frame_done_q;
    logic          tx_start;
    logic [15:0]   tx_word;
    logic          tx_busy;
    logic          tx_done;
    logic [7:0]    digit_row;

    always_ff @(posedge matrix_CLOCK_50 or negedge matrix_RESET_InLow) begin
        if (!matrix_RESET_InLow) state <= ST_INIT;
        else                     state <= state_nxt;
    end

    assign digit_row = snap[{word_idx, 3'b000} +: 8];

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        tx_word   = {REG_DIGIT0 + {5'd0, word_idx}, digit_row};
        case (state)
            ST_INIT: begin
                tx_word  = init_word(word_idx, INTENSITY);
                tx_start = !tx_busy;
                if (tx_done && word_idx == LAST_INIT)
                    state_nxt = matrix_enable_in ? ST_SNAP : ST_IDLE;
            end
            ST_SNAP: state_nxt = ST_REFRESH;
            ST_REFRESH: begin
                tx_start = !tx_busy;
                if (tx_done && word_idx == LAST_DIGIT)
                    state_nxt = matrix_enable_in ? ST_SNAP : ST_IDLE;
            end
            ST_IDLE: if (matrix_enable_in) state_nxt = ST_SNAP;
            default: state_nxt = ST_INIT;
        endcase
    end

    // The 3-bit index wraps freely; SNAP is what re-arms it for each frame.
    always_ff @(posedge matrix_CLOCK_50 or negedge matrix_RESET_InLow) begin
        if (!matrix_RESET_InLow) begin
            word_idx     <= 3'd0;
            snap         <= 64'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (state == ST_REFRESH) && tx_done && (word_idx == LAST_DIGIT);
            if (state == ST_SNAP) begin
                word_idx <= 3'd0;
                snap     <= {matrix_fila7_bus_in, matrix_fila6_bus_in, matrix_fila5_bus_in,
                             matrix_fila4_bus_in, matrix_fila3_bus_in, matrix_fila2_bus_in,
                             matrix_fila1_bus_in, matrix_fila0_bus_in};
            end else if (tx_done) begin
                word_idx <= word_idx + 3'd1;
            end
        end
    end

    cc_max7219_word_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_word_tx (
        .clk_sys (matrix_CLOCK_50),
        .rst_b   (matrix_RESET_InLow),
        .start   (tx_start),
        .word    (tx_word),
        .busy    (tx_busy),
        .done    (tx_done),
        .din     (matrix_din_out),
        .sclk    (matrix_sclk_out),
        .load    (matrix_load_out)
    );

    assign matrix_busy_out       = tx_busy || (state == ST_SNAP);
    assign matrix_frame_done_out = frame_done_q;

endmodule

// File: tb/tb_cc_matrix_max7219_tx.sv
// Bench for cc_matrix_max7219_tx: decodes the serial wire into words and
// compares them against a queue of expected words pushed by each scenario.
module tb_cc_matrix_max7219_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] fila [8];
    logic       din, sclk, load, busy, fd;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    int          fall_q [$];

    int          cyc = 0;
    int          words_done = 0;
    int          fd_count = 0;
    int          last_rise = 0;
    logic        prev_load = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        d1 = 1'b0, d2 = 1'b0;
    logic        in_word = 1'b0;
    int          edges = 0;
    int          stab_err = 0;
    int          after_cnt = 0;
    logic        after_bit = 1'b0;
    logic [15:0] sh = 16'd0;
    logic [15:0] exp_w;

    logic [7:0]  pat [8] = '{8'h20, 8'h30, 8'h38, 8'h3C, 8'h3C, 8'h38, 8'h30, 8'h20};
    logic [7:0]  ffs [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [15:0] iw  [5] = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A08, 16'h0C01};

    always #5 clk = ~clk;

    cc_matrix_max7219_tx #(
        .CLK_DIV   (2),
        .INTENSITY (4'h8)
    ) dut (
        .matrix_CLOCK_50       (clk),
        .matrix_RESET_InLow    (rst_n),
        .matrix_enable_in      (en),
        .matrix_fila7_bus_in   (fila[7]),
        .matrix_fila6_bus_in   (fila[6]),
        .matrix_fila5_bus_in   (fila[5]),
        .matrix_fila4_bus_in   (fila[4]),
        .matrix_fila3_bus_in   (fila[3]),
        .matrix_fila2_bus_in   (fila[2]),
        .matrix_fila1_bus_in   (fila[1]),
        .matrix_fila0_bus_in   (fila[0]),
        .matrix_din_out        (din),
        .matrix_sclk_out       (sclk),
        .matrix_load_out       (load),
        .matrix_busy_out       (busy),
        .matrix_frame_done_out (fd)
    );

    // Wire decoder and scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            in_word   = 1'b0;
            after_cnt = 0;
            prev_load = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (prev_load && !load) begin
                in_word  = 1'b1;
                edges    = 0;
                sh       = 16'd0;
                stab_err = 0;
                fall_q.push_back(cyc);
            end
            if (in_word && sclk && !prev_sclk) begin
                edges = edges + 1;
                sh    = {sh[14:0], din};
                if (din !== d1 || din !== d2) stab_err = stab_err + 1;
                after_bit = din;
                after_cnt = 1;
            end else if (after_cnt > 0) begin
                if (din !== after_bit) stab_err = stab_err + 1;
                after_cnt = after_cnt - 1;
            end
            if (in_word && !prev_load && load) begin
                in_word    = 1'b0;
                words_done = words_done + 1;
                last_rise  = cyc;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL word_unexpected got=%h expected none", sh);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (sh !== exp_w) begin
                        errors = errors + 1;
                        $display("FAIL word_value got=%h expected=%h", sh, exp_w);
                    end
                end
                checks = checks + 1;
                if (edges !== 16) begin
                    errors = errors + 1;
                    $display("FAIL sclk_edges got=%0d expected=16", edges);
                end
                checks = checks + 1;
                if (stab_err !== 0) begin
                    errors = errors + 1;
                    $display("FAIL din_stability violations=%0d expected=0", stab_err);
                end
            end
            if (fd) begin
                fd_count = fd_count + 1;
                checks = checks + 1;
                if (cyc - last_rise !== 4 || words_done < 13 || (words_done - 5) % 8 != 0) begin
                    errors = errors + 1;
                    $display("FAIL frame_done_timing delay=%0d expected=4 words=%0d", cyc - last_rise, words_done);
                end
            end
        end
        d2 = d1;
        d1 = din;
        prev_load = load;
        prev_sclk = sclk;
    end

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (words_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (words_done < n) begin
            errors++;
            $display("FAIL wait_words got=%0d expected=%0d", words_done, n);
        end
    endtask

    task automatic wait_load_low(input int budget, output int k);
        k = 0;
        while (load !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (load !== 1'b0) begin
            errors++;
            $display("FAIL wait_load_low load=%b expected=0", load);
        end
    endtask

    task automatic push_frame(input logic [7:0] r [8]);
        for (int i = 0; i < 8; i++) exp_q.push_back({8'(i + 1), r[i]});
    endtask

    task automatic test_reset();
        int k;
        rst_n = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 8; i++) fila[i] = pat[i];
        repeat (5) @(negedge clk);
        checks++;
        if ({load, sclk, din, busy, fd} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_levels got=%b expected=10000", {load, sclk, din, busy, fd});
        end
        rst_n = 1'b1;
        wait_load_low(50, k);
        // 18 cycles into 0x0F00: HIGH half of bit11 (a 1)
        repeat (18) @(negedge clk);
        checks++;
        if ({load, sclk, din, busy} !== 4'b0111) begin
            errors++;
            $display("FAIL midword_levels got=%b expected=0111", {load, sclk, din, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({load, sclk, din, busy, fd} !== 5'b10000) begin
            errors++;
            $display("FAIL async_reset got=%b expected=10000", {load, sclk, din, busy, fd});
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        fall_q.delete();
    endtask

    task automatic test_init();
        for (int i = 0; i < 5; i++) exp_q.push_back(iw[i]);
        wait_words(5, 5 * 80);
    endtask

    task automatic test_rows();
        push_frame(pat);
        wait_words(13, 8 * 80);
        repeat (8) @(negedge clk);
        checks++;
        if (fd_count !== 1) begin
            errors++;
            $display("FAIL frame1_done got=%0d expected=1", fd_count);
        end
    endtask

    task automatic test_tear();
        int k;
        push_frame(pat);
        push_frame(ffs);
        wait_words(15, 3 * 80);
        wait_load_low(20, k);
        for (int i = 0; i < 8; i++) fila[i] = 8'hFF;
        wait_words(21, 7 * 80);
        wait_words(29, 9 * 80);
        repeat (8) @(negedge clk);
        checks++;
        if (fd_count !== 3) begin
            errors++;
            $display("FAIL frame3_done got=%0d expected=3", fd_count);
        end
    endtask

    task automatic test_enable();
        int k;
        int nf;
        logic busy_seen;
        // frame 4 (all 0xFF), enable dropped during its 5th digit word
        push_frame(ffs);
        wait_words(33, 5 * 80);
        wait_load_low(20, k);
        en = 1'b0;
        wait_words(37, 4 * 80);
        repeat (8) @(negedge clk);
        checks++;
        if (fd_count !== 4) begin
            errors++;
            $display("FAIL frame4_done got=%0d expected=4", fd_count);
        end
        nf = fall_q.size();
        busy_seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got=%b expected=0", busy_seen);
        end
        checks++;
        if (fall_q.size() !== nf) begin
            errors++;
            $display("FAIL idle_load_falls got=%0d expected=%0d", fall_q.size() - nf, 0);
        end
        for (int i = 0; i < 8; i++) fila[i] = 8'h81 + 8'(i);
        for (int i = 0; i < 8; i++) exp_q.push_back({8'(i + 1), 8'h81 + 8'(i)});
        en = 1'b1;
        wait_load_low(20, k);
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL reenable_latency got=%0d expected=3", k);
        end
        en = 1'b0;
        wait_words(45, 9 * 80);
        repeat (8) @(negedge clk);
        checks++;
        if (fd_count !== 5 || busy !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL frame5_end fd=%0d busy=%b pending=%0d expected 5 0 0", fd_count, busy, exp_q.size());
        end
    endtask

    task automatic test_interval();
        int expd;
        checks++;
        if (fall_q.size() !== 45) begin
            errors++;
            $display("FAIL fall_count got=%0d expected=45", fall_q.size());
        end else begin
            for (int i = 0; i < 44; i++) begin
                if (i != 36) begin
                    expd = ((i + 1) >= 5 && (i + 1 - 5) % 8 == 0) ? 72 : 71;
                    checks++;
                    if (fall_q[i + 1] - fall_q[i] !== expd) begin
                        errors++;
                        $display("FAIL load_interval idx=%0d got=%0d expected=%0d", i, fall_q[i + 1] - fall_q[i], expd);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) fila[i] = 8'h00;
        test_reset();
        test_init();
        test_rows();
        test_tear();
        test_enable();
        test_interval();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
